// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU-side responder for the VIC register bus.
// Qualifies CPU cycles on the dot4x clock, issues one register-file read or
// write strobe per qualified phi-high half, and drives read data onto the
// bus (dbo/vic_write_db) until phi falls.
//
// Handshake/timing contract: the qualification point is tick QUAL_TICK of
// the phi-high half. reg_re is a one-cycle strobe and reg_rdata is sampled
// on the following cycle. reg_we is a registered one-cycle strobe and
// reg_wdata is stable while it is high. rd_clr is a one-cycle strobe for
// the clear-on-read registers. At most one of the three strobes is high in
// any cycle.
module cpu_bus_responder #(
    parameter int unsigned QUAL_TICK = 2,
    parameter int unsigned WR_TICK   = 12,
    parameter logic [5:0]  LAST_REG  = 6'h2E
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic       clk_phi,
    input  logic       ce,
    input  logic       rw,
    input  logic       aec,
    input  logic [5:0] adi,
    input  logic [7:0] dbi,
    input  logic [7:0] reg_rdata,
    output logic [5:0] reg_addr,
    output logic       reg_re,
    output logic       reg_we,
    output logic [7:0] reg_wdata,
    output logic       rd_clr,
    output logic [7:0] dbo,
    output logic       vic_write_db,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_CAP   = 3'd2,
        RD_DRIVE = 3'd3,
        WR_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [4:0] QT       = 5'(QUAL_TICK);
    localparam logic [4:0] WT       = 5'(WR_TICK);
    localparam logic [4:0] TICK_MAX = 5'd31;

    state_t     state_q, state_d;
    logic       phi_d_q, phi_d_d;
    logic [4:0] tick_q, tick_d;
    logic [5:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       rd_clr_q, rd_clr_d;
    logic [7:0] dbo_q, dbo_d;
    logic       drive_q, drive_d;

    logic phi_rise, phi_fall, qualify, unmapped, clr_addr, wr_point;

    assign phi_rise = clk_phi & ~phi_d_q;
    assign phi_fall = ~clk_phi & phi_d_q;
    assign unmapped = (reg_addr_q > LAST_REG);
    assign clr_addr = (reg_addr_q == 6'h1E) || (reg_addr_q == 6'h1F);
    // tick_q only passes QUAL_TICK once per phi-high half, so at most one
    // qualification can happen per half.
    assign qualify  = (state_q == IDLE) && clk_phi && !phi_rise &&
                      (tick_q == QT) && !ce && aec;
    assign wr_point = clk_phi && (tick_q == WT);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phi_d_q     <= 1'b0;
            tick_q      <= 5'd0;
            reg_addr_q  <= 6'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            rd_clr_q    <= 1'b0;
            dbo_q       <= 8'd0;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_d_q     <= phi_d_d;
            tick_q      <= tick_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            rd_clr_q    <= rd_clr_d;
            dbo_q       <= dbo_d;
            drive_q     <= drive_d;
        end
    end

    // Next-state logic; a phi rise outside IDLE means a missed fall and
    // forces the FSM back to IDLE.
    always_comb begin
        state_d = state_q;
        if (phi_rise && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (qualify) state_d = rw ? RD_REQ : WR_WAIT;
                RD_REQ:   state_d = phi_fall ? IDLE : RD_CAP;
                RD_CAP:   state_d = phi_fall ? IDLE : RD_DRIVE;
                RD_DRIVE: begin
                    if (phi_fall)  state_d = IDLE;
                    else if (ce)   state_d = DONE;
                end
                WR_WAIT: begin
                    if (phi_fall)      state_d = IDLE;
                    else if (ce)       state_d = DONE;
                    else if (wr_point) state_d = DONE;
                end
                DONE:     if (!clk_phi) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: phase counter, address latch, strobes, bus drive.
    always_comb begin
        phi_d_d     = clk_phi;
        tick_d      = tick_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        rd_clr_d    = 1'b0;
        dbo_d       = dbo_q;
        drive_d     = 1'b0;

        if (phi_rise)
            tick_d = 5'd0;
        else if (clk_phi && (tick_q != TICK_MAX))
            tick_d = tick_q + 5'd1;

        if (qualify)
            reg_addr_d = adi;

        if (!phi_rise) begin
            case (state_q)
                RD_CAP: begin
                    if (phi_fall) begin
                        // Phase ended before the drive could start: no drive,
                        // but the read happened so the clear still applies.
                        rd_clr_d = clr_addr;
                    end else begin
                        dbo_d   = unmapped ? 8'hFF : reg_rdata;
                        drive_d = 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if (phi_fall)
                        rd_clr_d = clr_addr;
                    else
                        drive_d = !ce;
                end
                WR_WAIT: begin
                    if (!phi_fall && !ce && wr_point && !unmapped) begin
                        reg_we_d    = 1'b1;
                        reg_wdata_d = dbi;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; the drive enable is gated by phi so it drops in the fall cycle.
    always_comb begin
        reg_addr     = reg_addr_q;
        reg_re       = (state_q == RD_REQ) && !phi_rise;
        reg_we       = reg_we_q;
        reg_wdata    = reg_wdata_q;
        rd_clr       = rd_clr_q;
        dbo          = dbo_q;
        vic_write_db = drive_q && clk_phi;
        dbg_state_o  = state_q;
    end

endmodule
